// File: rtl/mult_ctrl.sv
// ============================================================================
// mult_ctrl : sequencer for a shift-add multiplier accumulator
//   Issues Load/Ad/Sh strobes for one unsigned WIDTH x WIDTH multiply per start.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mult_ctrl #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             St,
  input  logic             Clr,
  input  logic             M,
  output logic             Load,
  output logic             Sh,
  output logic             Ad,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;
  logic   last_step;

  // The step in progress is the final one when WIDTH-1 shifts are already done.
  assign last_step = (Count == CNT_W'(WIDTH - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      Count <= '0;
    end else if (Clr) begin
      state <= IDLE;
      Count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (St) state <= LOAD;
        end
        LOAD: begin
          Count <= '0;
          state <= CHECK;
        end
        CHECK: begin
          if (M) begin
            state <= SHIFT;
          end else begin
            Count <= Count + CNT_W'(1);
            state <= last_step ? DONE : CHECK;
          end
        end
        SHIFT: begin
          Count <= Count + CNT_W'(1);
          state <= last_step ? DONE : CHECK;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes are decoded from the registered state; CHECK needs the live
  // multiplier bit, and Clr must silence everything in the cycle it is seen.
  always_comb begin
    Load = 1'b0;
    Sh   = 1'b0;
    Ad   = 1'b0;
    Done = 1'b0;
    Busy = (state != IDLE);
    if (!Clr) begin
      case (state)
        LOAD:    Load = 1'b1;
        CHECK: begin
          Ad = M;
          Sh = ~M;
        end
        SHIFT:   Sh   = 1'b1;
        DONE:    Done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_ctrl.sv
// ============================================================================
// tb_mult_ctrl : randomized self-checking bench for mult_ctrl with an ACC model
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_mult_ctrl;

  localparam int W = 16;

  logic         Clk;
  logic         Rst_n;
  logic         St;
  logic         Clr;
  logic         M;
  logic         Load;
  logic         Sh;
  logic         Ad;
  logic         Busy;
  logic         Done;
  logic [3:0]   Count;

  logic [2*W:0] acc = '0;
  logic [W-1:0] mcand = '0;
  logic [W-1:0] mplier = '0;

  int n_checks = 0;
  int n_fail   = 0;

  mult_ctrl #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .St    (St),
    .Clr   (Clr),
    .M     (M),
    .Load  (Load),
    .Sh    (Sh),
    .Ad    (Ad),
    .Busy  (Busy),
    .Done  (Done),
    .Count (Count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Accumulator the controller steers; its LSB is the current multiplier bit.
  always @(posedge Clk) begin
    if (Load)    acc <= {{(W+1){1'b0}}, mplier};
    else if (Ad) acc[2*W:W] <= acc[2*W:W] + {1'b0, mcand};
    else if (Sh) acc <= acc >> 1;
  end
  assign M = acc[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Observed outputs packed as {Load, Sh, Ad, Done, Busy}.
  function automatic logic [4:0] obs();
    return {Load, Sh, Ad, Done, Busy};
  endfunction

  task automatic check_cycle(input logic [4:0] exp_s, input int exp_c);
    check("strobes", 32'(obs()), 32'(exp_s));
    check("count", 32'(Count), 32'(exp_c));
    check("onehot", 32'($countones({Load, Sh, Ad}) <= 1), 32'd1);
  endtask

  // st_mode: 0 = St pulse, 1 = St toggled randomly while busy, 2 = St held high.
  // abort:   0 = none, 1 = Clr in SHIFT at Count 7, 2 = reset in first Ad CHECK.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int st_mode, input int abort);
    logic [4:0] eq[$];
    int         ec[$];
    int         n_done;
    int         abort_k;
    mcand  = a;
    mplier = b;
    // Expected per-cycle activity straight from the multiplier bits.
    eq.push_back(5'b10001); ec.push_back(0);
    for (int i = 0; i < W; i++) begin
      if (b[i]) begin
        eq.push_back(5'b00101); ec.push_back(i);
      end
      eq.push_back(5'b01001); ec.push_back(i);
    end
    eq.push_back(5'b00011); ec.push_back(0);
    eq.push_back(5'b00000); ec.push_back(0);
    n_done  = eq.size() - 1;
    abort_k = 0;
    for (int i = 1; i < eq.size(); i++) begin
      if (abort_k == 0 && abort == 1 && eq[i] == 5'b01001 && eq[i-1] == 5'b00101 && ec[i] == 7)
        abort_k = i + 1;
      if (abort_k == 0 && abort == 2 && eq[i] == 5'b00101)
        abort_k = i + 1;
    end
    St = 1'b1;
    for (int k = 1; k <= n_done + 1; k++) begin
      @(negedge Clk);
      check_cycle(eq[k-1], ec[k-1]);
      if (k == n_done)
        check("product", acc[2*W-1:0], 32'(a) * 32'(b));
      if (k == abort_k && abort == 1) begin
        Clr = 1'b1;
        St  = 1'b0;
        #1;
        check("clr_strobes", 32'({Load, Sh, Ad, Done}), 32'd0);
        @(negedge Clk);
        check_cycle(5'b00000, 0);
        Clr = 1'b0;
        @(negedge Clk);
        check_cycle(5'b00000, 0);
        return;
      end
      if (k == abort_k && abort == 2) begin
        Rst_n = 1'b0;
        St    = 1'b0;
        #1;
        check("rst_async", 32'({obs(), Count}), 32'd0);
        @(negedge Clk);
        check_cycle(5'b00000, 0);
        Rst_n = 1'b1;
        @(negedge Clk);
        check_cycle(5'b00000, 0);
        return;
      end
      case (st_mode)
        1:       St = (k <= n_done) ? 1'($urandom_range(0, 1)) : 1'b0;
        2:       St = 1'b1;
        default: St = 1'b0;
      endcase
    end
  endtask

  initial begin
    Rst_n = 1'b1;
    St    = 1'b0;
    Clr   = 1'b0;
    #2 Rst_n = 1'b0;
    #1 check("rst_async0", 32'({obs(), Count}), 32'd0);
    repeat (2) begin
      @(negedge Clk);
      check_cycle(5'b00000, 0);
    end
    Rst_n = 1'b1;
    repeat (5) begin
      @(negedge Clk);
      check_cycle(5'b00000, 0);
    end

    run_op(16'($urandom), 16'd5, 0, 0);
    run_op(16'($urandom), 16'h0000, 0, 0);
    run_op(16'($urandom), 16'hFFFF, 0, 0);

    // Two back-to-back operations with St held continuously.
    run_op(16'($urandom), 16'h0000, 2, 0);
    run_op(16'($urandom), 16'h0000, 0, 0);

    // Clr beats St and is harmless in IDLE.
    St  = 1'b1;
    Clr = 1'b1;
    @(negedge Clk);
    check_cycle(5'b00000, 0);
    St  = 1'b0;
    Clr = 1'b0;
    @(negedge Clk);
    check_cycle(5'b00000, 0);

    run_op(16'($urandom), 16'($urandom) | 16'h0080, 0, 1);
    run_op(16'($urandom), 16'($urandom) | 16'h0010, 0, 2);
    run_op(16'($urandom), 16'($urandom), 1, 0);

    for (int n = 0; n < 30; n++)
      run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 1)), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
